lift_call_scheduler: RTL and testbench

//   SCAN (elevator-algorithm) scheduler/sequencer for a FLOORS-level lift car.

---
 rtl/lift_call_scheduler.sv | 139 +++++++++++++
 tb/tb_lift_call_scheduler.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/lift_call_scheduler.sv
// SCAN lift-call scheduler: latches floor calls, sequences MOVE/DOOR with down-counter timers.
// Optional LIFT_SCHED_DOOR_HOLD_EN adds i_door_hold to extend the door dwell.
module lift_call_scheduler #(
  parameter int FLOORS      = 4,
  parameter int MOVE_CYCLES = 8,
  parameter int DOOR_CYCLES = 4
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [FLOORS-1:0] i_call_req,
`ifdef LIFT_SCHED_DOOR_HOLD_EN
  input  logic              i_door_hold,
`endif
  output logic [FLOORS-1:0] o_floor,
  output logic [FLOORS-1:0] o_pending,
  output logic              o_moving_up,
  output logic              o_moving_down,
  output logic              o_door_open,
  output logic              o_busy
);

  // state  | meaning
  // S_IDLE | car stopped, door closed, choosing next action from pending
  // S_MOVE | travelling one floor in r_dir_up direction
  // S_DOOR | door open at current floor, calls to this floor absorbed
  typedef enum logic [1:0] {S_IDLE, S_MOVE, S_DOOR} state_t;

  localparam int CNT_MAX = (MOVE_CYCLES > DOOR_CYCLES) ? MOVE_CYCLES : DOOR_CYCLES;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  state_t            r_state;
  logic              r_dir_up;
  logic [CW-1:0]     r_cnt;
  logic [FLOORS-1:0] r_floor;
  logic [FLOORS-1:0] r_pending;

  state_t            w_state_nxt;
  logic              w_dir_up_nxt;
  logic [CW-1:0]     w_cnt_nxt;
  logic [FLOORS-1:0] w_floor_nxt;
  logic [FLOORS-1:0] w_pending_nxt;
  logic              w_clear;
  logic              w_hold;
  logic [FLOORS-1:0] w_mask_below;
  logic [FLOORS-1:0] w_mask_above;
  logic              w_any_below;
  logic              w_any_above;
  logic              w_ahead;
  logic              w_behind;

`ifdef LIFT_SCHED_DOOR_HOLD_EN
  assign w_hold = i_door_hold;
`else
  assign w_hold = 1'b0;
`endif

  // floor is one-hot, so floor-1 marks every floor strictly below the car
  assign w_mask_below = r_floor - FLOORS'(1);
  assign w_mask_above = ~(w_mask_below | r_floor);
  assign w_any_below  = |(r_pending & w_mask_below);
  assign w_any_above  = |(r_pending & w_mask_above);
  assign w_ahead      = r_dir_up ? w_any_above : w_any_below;
  assign w_behind     = r_dir_up ? w_any_below : w_any_above;

  always_comb begin
    w_state_nxt  = r_state;
    w_dir_up_nxt = r_dir_up;
    w_cnt_nxt    = r_cnt;
    w_floor_nxt  = r_floor;
    w_clear      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (|(r_pending & r_floor)) begin
          w_state_nxt = S_DOOR;
          w_cnt_nxt   = CW'(DOOR_CYCLES - 1);
          w_clear     = 1'b1;
        end else if (w_ahead) begin
          w_state_nxt = S_MOVE;
          w_cnt_nxt   = CW'(MOVE_CYCLES - 1);
        end else if (w_behind) begin
          w_state_nxt  = S_MOVE;
          w_dir_up_nxt = ~r_dir_up;
          w_cnt_nxt    = CW'(MOVE_CYCLES - 1);
        end
      end
      S_MOVE: begin
        if (r_cnt == '0) begin
          w_state_nxt = S_IDLE;
          if (r_dir_up && !r_floor[FLOORS-1]) begin
            w_floor_nxt = r_floor << 1;
          end else if (!r_dir_up && !r_floor[0]) begin
            w_floor_nxt = r_floor >> 1;
          end
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end
      S_DOOR: begin
        w_clear = 1'b1;
        if (w_hold) begin
          w_cnt_nxt = CW'(DOOR_CYCLES - 1);
        end else if (r_cnt == '0) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
    w_pending_nxt = (r_pending | i_call_req) & ~({FLOORS{w_clear}} & r_floor);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= S_IDLE;
      r_dir_up  <= 1'b1;
      r_cnt     <= '0;
      r_floor   <= FLOORS'(1);
      r_pending <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_dir_up  <= w_dir_up_nxt;
      r_cnt     <= w_cnt_nxt;
      r_floor   <= w_floor_nxt;
      r_pending <= w_pending_nxt;
    end
  end

  assign o_floor       = r_floor;
  assign o_pending     = r_pending;
  assign o_moving_up   = (r_state == S_MOVE) && r_dir_up;
  assign o_moving_down = (r_state == S_MOVE) && !r_dir_up;
  assign o_door_open   = (r_state == S_DOOR);
  assign o_busy        = (r_state != S_IDLE) || (r_pending != '0);

endmodule

// File: tb/tb_lift_call_scheduler.sv
// Bench for lift_call_scheduler: vector table, SCAN stop-order sequence, door dwell/hold,
// and randomized traffic against an index-based reference model.
module tb_lift_call_scheduler;
  localparam int FLOORS      = 4;
  localparam int MOVE_CYCLES = 8;
  localparam int DOOR_CYCLES = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic [FLOORS-1:0] call_req;
  logic              hold_drv;
  logic [FLOORS-1:0] floor_o;
  logic [FLOORS-1:0] pending_o;
  logic              up_o, dn_o, door_o, busy_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lift_call_scheduler #(.FLOORS(FLOORS), .MOVE_CYCLES(MOVE_CYCLES), .DOOR_CYCLES(DOOR_CYCLES)) dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_call_req   (call_req),
`ifdef LIFT_SCHED_DOOR_HOLD_EN
    .i_door_hold  (hold_drv),
`endif
    .o_floor      (floor_o),
    .o_pending    (pending_o),
    .o_moving_up  (up_o),
    .o_moving_down(dn_o),
    .o_door_open  (door_o),
    .o_busy       (busy_o)
  );

  // reference model: floor as an index, mode 0=idle 1=move 2=door, m_left = cycles left in mode
  int              m_floor = 0;
  logic [FLOORS-1:0] m_pend = '0;
  int              m_mode  = 0;
  int              m_left  = 0;
  bit              m_up    = 1'b1;

  task automatic model_step(input logic rst, input logic [FLOORS-1:0] req, input logic hold);
    logic [FLOORS-1:0] np;
    bit ahead, behind;
    if (rst) begin
      m_floor = 0; m_pend = '0; m_mode = 0; m_left = 0; m_up = 1'b1;
      return;
    end
    np = m_pend | req;
    case (m_mode)
      0: begin
        ahead = 0; behind = 0;
        for (int f = 0; f < FLOORS; f++) begin
          if (m_pend[f] && f != m_floor) begin
            if ((f > m_floor) == m_up) ahead = 1;
            else behind = 1;
          end
        end
        if (m_pend[m_floor]) begin
          m_mode = 2; m_left = DOOR_CYCLES; np[m_floor] = 1'b0;
        end else if (ahead) begin
          m_mode = 1; m_left = MOVE_CYCLES;
        end else if (behind) begin
          m_up = !m_up; m_mode = 1; m_left = MOVE_CYCLES;
        end
      end
      1: begin
        m_left--;
        if (m_left == 0) begin
          m_floor += m_up ? 1 : -1;
          m_mode = 0;
        end
      end
      default: begin
        np[m_floor] = 1'b0;
        if (hold) m_left = DOOR_CYCLES;
        else begin
          m_left--;
          if (m_left == 0) m_mode = 0;
        end
      end
    endcase
    m_pend = np;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(reset, call_req, hold_drv);
    #1;
  endtask

  task automatic check_model(input string tag);
    logic [FLOORS-1:0] ef;
    logic ed, eu, edn, eb;
    ef  = FLOORS'(1 << m_floor);
    ed  = (m_mode == 2);
    eu  = (m_mode == 1) && m_up;
    edn = (m_mode == 1) && !m_up;
    eb  = (m_mode != 0) || (m_pend != '0);
    checks++;
    if (floor_o !== ef || pending_o !== m_pend || door_o !== ed || up_o !== eu ||
        dn_o !== edn || busy_o !== eb || !$onehot(floor_o) || (up_o && dn_o)) begin
      errors++;
      $display("FAIL %s t=%0t floor got %b exp %b pend got %b exp %b door %b/%b up %b/%b dn %b/%b busy %b/%b",
               tag, $time, floor_o, ef, pending_o, m_pend, door_o, ed, up_o, eu, dn_o, edn, busy_o, eb);
    end
  endtask

  // waits for the door at an expected floor, then measures the dwell
  task automatic wait_stop(input logic [FLOORS-1:0] exp_floor, input string tag);
    int k;
    k = 0;
    while (!door_o && k < 80) begin tick(); check_model(tag); k++; end
    checks++;
    if (!door_o || floor_o !== exp_floor) begin
      errors++;
      $display("FAIL %s stop got floor %b door %b exp floor %b door 1", tag, floor_o, door_o, exp_floor);
    end
    k = 1;
    while (door_o && k < 20) begin tick(); check_model(tag); if (door_o) k++; end
    checks++;
    if (k != DOOR_CYCLES) begin
      errors++;
      $display("FAIL %s dwell got %0d cycles exp %0d", tag, k, DOOR_CYCLES);
    end
  endtask

  typedef struct {
    logic              rst;
    logic [FLOORS-1:0] req;
    int                n;
    logic [FLOORS-1:0] floor;
    logic [FLOORS-1:0] pend;
    logic              door, up, dn, busy;
  } vec_t;

  vec_t vecs[$];

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    reset = 1'b1; call_req = '0; hold_drv = 1'b0;

    //               rst   req    n  floor  pend   door up dn busy
    vecs.push_back('{1'b1, 4'b0000, 2, 4'b0001, 4'b0000, 0, 0, 0, 0});
    vecs.push_back('{1'b0, 4'b0001, 1, 4'b0001, 4'b0001, 0, 0, 0, 1});
    vecs.push_back('{1'b0, 4'b0000, 1, 4'b0001, 4'b0000, 1, 0, 0, 1});
    vecs.push_back('{1'b0, 4'b0000, 3, 4'b0001, 4'b0000, 1, 0, 0, 1});
    vecs.push_back('{1'b0, 4'b0000, 1, 4'b0001, 4'b0000, 0, 0, 0, 0});
    vecs.push_back('{1'b0, 4'b1000, 1, 4'b0001, 4'b1000, 0, 0, 0, 1});
    vecs.push_back('{1'b0, 4'b0000, 1, 4'b0001, 4'b1000, 0, 1, 0, 1});
    vecs.push_back('{1'b0, 4'b0000, 7, 4'b0001, 4'b1000, 0, 1, 0, 1});
    vecs.push_back('{1'b0, 4'b0000, 1, 4'b0010, 4'b1000, 0, 0, 0, 1});
    vecs.push_back('{1'b0, 4'b0000, 1, 4'b0010, 4'b1000, 0, 1, 0, 1});
    vecs.push_back('{1'b0, 4'b0000, 8, 4'b0100, 4'b1000, 0, 0, 0, 1});
    vecs.push_back('{1'b0, 4'b0000, 9, 4'b1000, 4'b1000, 0, 0, 0, 1});
    vecs.push_back('{1'b0, 4'b0000, 1, 4'b1000, 4'b0000, 1, 0, 0, 1});
    vecs.push_back('{1'b0, 4'b0000, 3, 4'b1000, 4'b0000, 1, 0, 0, 1});
    vecs.push_back('{1'b0, 4'b0000, 1, 4'b1000, 4'b0000, 0, 0, 0, 0});
    vecs.push_back('{1'b0, 4'b0001, 1, 4'b1000, 4'b0001, 0, 0, 0, 1});
    vecs.push_back('{1'b0, 4'b0000, 1, 4'b1000, 4'b0001, 0, 0, 1, 1});
    vecs.push_back('{1'b0, 4'b0110, 1, 4'b1000, 4'b0111, 0, 0, 1, 1});
    vecs.push_back('{1'b1, 4'b0000, 1, 4'b0001, 4'b0000, 0, 0, 0, 0});
    vecs.push_back('{1'b0, 4'b0001, 1, 4'b0001, 4'b0001, 0, 0, 0, 1});
    vecs.push_back('{1'b0, 4'b0001, 1, 4'b0001, 4'b0000, 1, 0, 0, 1});
    vecs.push_back('{1'b0, 4'b0001, 2, 4'b0001, 4'b0000, 1, 0, 0, 1});
    vecs.push_back('{1'b0, 4'b0000, 2, 4'b0001, 4'b0000, 0, 0, 0, 0});

    foreach (vecs[i]) begin
      reset = vecs[i].rst;
      call_req = vecs[i].req;
      repeat (vecs[i].n) tick();
      checks++;
      if (floor_o !== vecs[i].floor || pending_o !== vecs[i].pend || door_o !== vecs[i].door ||
          up_o !== vecs[i].up || dn_o !== vecs[i].dn || busy_o !== vecs[i].busy) begin
        errors++;
        $display("FAIL vec%0d floor %b/%b pend %b/%b door %b/%b up %b/%b dn %b/%b busy %b/%b (got/exp)",
                 i, floor_o, vecs[i].floor, pending_o, vecs[i].pend, door_o, vecs[i].door,
                 up_o, vecs[i].up, dn_o, vecs[i].dn, busy_o, vecs[i].busy);
      end
    end
    reset = 1'b0; call_req = '0;

    // SCAN order: going up to 1, calls at 0 and 3 arrive mid-move
    call_req = 4'b0010; tick(); check_model("scan");
    call_req = 4'b0000; tick(); check_model("scan");
    tick(); check_model("scan");
    tick(); check_model("scan");
    call_req = 4'b1001; tick(); check_model("scan");
    call_req = 4'b0000;
    wait_stop(4'b0010, "scan_stop1");
    wait_stop(4'b1000, "scan_stop3");
    wait_stop(4'b0001, "scan_stop0");
    k = 0;
    while (busy_o && k < 40) begin tick(); check_model("scan_end"); k++; end
    checks++;
    if (busy_o || pending_o !== 4'b0000) begin
      errors++;
      $display("FAIL scan_end busy %b pend %b exp busy 0 pend 0000", busy_o, pending_o);
    end

`ifdef LIFT_SCHED_DOOR_HOLD_EN
    call_req = 4'b0001; tick(); check_model("hold");
    call_req = 4'b0000; tick(); check_model("hold");
    hold_drv = 1'b1;
    repeat (10) begin tick(); check_model("hold_on"); end
    hold_drv = 1'b0;
    k = 0;
    while (door_o && k < 20) begin tick(); check_model("hold_rel"); k++; end
    checks++;
    if (k != DOOR_CYCLES) begin
      errors++;
      $display("FAIL hold_release got %0d cycles exp %0d", k, DOOR_CYCLES);
    end
`endif

    for (int c = 0; c < 3000; c++) begin
      reset    = ($urandom_range(0, 299) == 0);
      call_req = ($urandom_range(0, 5) == 0) ? FLOORS'($urandom) : '0;
`ifdef LIFT_SCHED_DOOR_HOLD_EN
      hold_drv = ($urandom_range(0, 7) == 0);
`endif
      tick();
      check_model("random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
